ica_weight_update: RTL
======================

Name: ica_weight_update

Overview:
- Parametrised fixed-point engine that performs one FastICA fixed-point iteration for a single component: w+ = E{x·g(wᵀx)} − E{g'(wᵀx)}·w.
- Samples are streamed in one column per beat, with all N_CH channels in parallel.
- Generalises the earlier single-configuration unmixing loop: channel count, sample count, width and Q-format are parameters, the nonlinearity is selectable, and the block adds a valid/ready handshake and saturation reporting.
- Sits between the whitened-sample buffer and the deflation/normalisation stage.

Parameters:
- N_CH, 8, number of input channels (≥1).
- M, 512, samples per iteration; power of two, ≥2; LOG2_M = log2(M).
- DATA_W, 32, signed width of samples, weights and outputs.
- FRAC, 16, fractional bits of the Q format (1.0 = 2^FRAC).
- G_MODE, 0, nonlinearity: 0 = pow3 (g=y³, g'=3y²); 1 = skew (g=y², g'=2y).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  begin an iteration; sampled only in IDLE
- w_in  in  N_CH x DATA_W  current weight vector, captured on accepted start
- s_valid  in  1  sample column valid
- s_ready  out  1  sample column accepted when s_valid && s_ready
- s_data  in  N_CH x DATA_W  one sample per channel
- w_out  out  N_CH x DATA_W  updated weight vector w+
- w_valid  out  1  w_out valid; held until w_ready
- w_ready  in  1  downstream accepts w_out
- busy  out  1  high in every state except IDLE
- sat_flag  out  1  sticky: any saturation during the current iteration

Behaviour:
- Reset (synchronous, active-high, clk and rst): state=IDLE; s_ready=0, w_valid=0, busy=0, sat_flag=0, w_out=0; accumulators and counters cleared. A reset mid-operation aborts the iteration with no output.
- States: IDLE, RUN, DRAIN, FINAL, DONE.
- IDLE:
  - start=1 latches w_in, clears accumulators and sat_flag, and moves to RUN next cycle.
  - start in any other state is ignored.
- RUN:
  - s_ready=1. Each handshake pushes a column into a 3-stage pipeline and increments the beat count.
  - Gaps in s_valid stall only the input; results do not change.
  - After the M-th accepted beat, s_ready drops the next cycle and the state moves to DRAIN.
- Pipeline, with sat(v) = clamp to DATA_W signed range (setting sat_flag when it clamps) and >>> = arithmetic shift (floor):
  - S1: y = sat((Σ w_i·x_i) >>> FRAC).
  - S2, pow3: g = sat((sat((y·y) >>> FRAC)·y) >>> FRAC) and g' = sat((3·y·y) >>> FRAC).
  - S2, skew: g = sat((y·y) >>> FRAC) and g' = sat(2·y).
  - S3: acc_x[i] += x_i·g at full 2·DATA_W precision; acc_d += g'.
  - Accumulator width is 2·DATA_W + LOG2_M + 1, so accumulators never wrap.
- DRAIN: exactly 3 cycles to flush the pipeline.
- FINAL:
  - One channel per cycle (N_CH cycles, i = 0..N_CH−1), using one shared multiplier.
  - a_i = acc_x[i] >>> (FRAC + LOG2_M); b = acc_d >>> LOG2_M; w_out[i] = sat(a_i − ((b·w_i) >>> FRAC)).
- DONE:
  - w_valid=1; w_out and sat_flag are held stable.
  - On w_valid && w_ready: w_valid=0 next cycle and the state returns to IDLE.
  - A start in that same cycle is ignored; the earliest new start is the following cycle.
- Latency: with start at cycle 0 and s_valid continuously high, beats are accepted in cycles 1..M and w_valid rises at cycle M+4+N_CH. Every input-gap cycle adds exactly one cycle.
- sat_flag is cleared only by reset or by an accepted start.

Test Plan:
All scenarios use N_CH=2, M=4, DATA_W=16, FRAC=8.

1. Pow3, basic: G_MODE=0, w_in=(256,0), ch0 = 256,256,−256,−256, ch1 = 0 → w_out=(−512,0), sat_flag=0; w_valid rises at cycle 10 after start.
2. Skew, same data: G_MODE=1 → w_out=(0,0), sat_flag=0.
3. Saturation: G_MODE=0, w_in=(256,0), ch0 = 32767×4, ch1 = 0 → w_out=(32767,0), sat_flag=1. The next clean iteration with scenario-1 data reports sat_flag=0.
4. Input backpressure: scenario 1 with s_valid low for 3 cycles between beats 2 and 3 → identical w_out; w_valid rises at cycle 13. s_ready=0 outside RUN, and s_valid there has no effect.
5. Output stall: hold w_ready=0 for 5 cycles in DONE → w_out stable, busy=1, and a start pulse is ignored. A start pulse in the cycle w_ready=1 is also ignored; a start in the following cycle is accepted.
6. Reset mid-RUN: assert rst after 2 beats → all outputs at reset values next cycle. A fresh scenario-1 run then yields (−512,0).

Source files
------------

// File: rtl/ica_weight_update.sv
// ica_weight_update
// One FastICA fixed-point iteration for a single component:
//   w+ = E{x*g(w'x)} - E{g'(w'x)}*w
// Sample columns stream in one per beat through a 3-stage pipeline.
// After M beats the pipeline drains. A shared multiplier then produces one
// output channel per cycle. The result is held until downstream accepts it.
//
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   start      begin an iteration (sampled only in IDLE), latches w_in
//   w_in       current weight vector, N_CH x DATA_W signed
//   s_valid    sample column valid
//   s_ready    sample column accepted on s_valid && s_ready
//   s_data     sample column, N_CH x DATA_W signed
//   w_out      updated weight vector, N_CH x DATA_W signed
//   w_valid    w_out valid, held until w_ready
//   w_ready    downstream accepts w_out
//   busy       high in every state except IDLE
//   sat_flag   sticky, any clamp during the current iteration
module ica_weight_update #(
  parameter int N_CH   = 8,
  parameter int M      = 512,
  parameter int DATA_W = 32,
  parameter int FRAC   = 16,
  parameter int G_MODE = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [N_CH-1:0][DATA_W-1:0]  w_in,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic [N_CH-1:0][DATA_W-1:0]  s_data,
  output logic [N_CH-1:0][DATA_W-1:0]  w_out,
  output logic                         w_valid,
  input  logic                         w_ready,
  output logic                         busy,
  output logic                         sat_flag
);

  localparam int LOG2_M = $clog2(M);
  localparam int ACC_W  = 2*DATA_W + LOG2_M + 1;
  localparam int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int BEAT_W = LOG2_M + 1;
  localparam int WIDE   = 3*DATA_W + LOG2_M + CH_W + 4;

  localparam logic signed [WIDE-1:0] MAX_V = {{(WIDE-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [WIDE-1:0] MIN_V = {{(WIDE-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(M-1);
  localparam logic [CH_W-1:0]   LAST_CH   = CH_W'(N_CH-1);

  typedef enum logic [2:0] {IDLE, RUN, DRAIN, FINAL, DONE} state_t;

  // All intermediate arithmetic is carried in one wide signed width that
  // holds every product and sum exactly, so clamping is the only place
  // where precision can be lost.
  function automatic logic signed [WIDE-1:0] extD(input logic [DATA_W-1:0] v);
    return {{(WIDE-DATA_W){v[DATA_W-1]}}, v};
  endfunction

  function automatic logic signed [WIDE-1:0] extA(input logic [ACC_W-1:0] v);
    return {{(WIDE-ACC_W){v[ACC_W-1]}}, v};
  endfunction

  function automatic logic signed [ACC_W-1:0] extDA(input logic [DATA_W-1:0] v);
    return {{(ACC_W-DATA_W){v[DATA_W-1]}}, v};
  endfunction

  function automatic logic [DATA_W-1:0] satV(input logic signed [WIDE-1:0] v);
    if (v > MAX_V)      return MAX_V[DATA_W-1:0];
    else if (v < MIN_V) return MIN_V[DATA_W-1:0];
    else                return v[DATA_W-1:0];
  endfunction

  function automatic logic ovf(input logic signed [WIDE-1:0] v);
    return (v > MAX_V) || (v < MIN_V);
  endfunction

  state_t r_state, w_next;
  logic [DATA_W-1:0] r_w [N_CH];
  logic [DATA_W-1:0] r_wOut [N_CH];
  logic signed [ACC_W-1:0] r_accX [N_CH];
  logic signed [ACC_W-1:0] r_accD;
  logic [BEAT_W-1:0] r_beat;
  logic [1:0] r_drain;
  logic [CH_W-1:0] r_idx;
  logic r_sat;
  logic r_s1Valid, r_s2Valid;
  logic [DATA_W-1:0] r_s1Y, r_s2G, r_s2Gd;
  logic [DATA_W-1:0] r_s1X [N_CH];
  logic [DATA_W-1:0] r_s2X [N_CH];

  logic w_accept, w_beat;
  logic signed [WIDE-1:0] w_dot, w_y1Full;
  logic [DATA_W-1:0] w_y1;
  logic w_y1Ovf;
  logic signed [WIDE-1:0] w_yExt, w_yy, w_yyShift, w_sq, w_gFull, w_gdFull;
  logic [DATA_W-1:0] w_g, w_gd;
  logic w_s2Ovf;
  logic signed [WIDE-1:0] w_a, w_b, w_fin;
  logic [DATA_W-1:0] w_finSat;
  logic w_finOvf;

  // State register; a reset from any state abandons the iteration.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Next-state and handshake outputs. The RUN exit needs no s_ready term
  // because s_ready is high throughout RUN. A start during the DONE
  // handshake cycle is ignored, because start is sampled only in IDLE.
  always_comb begin
    w_next   = r_state;
    s_ready  = 1'b0;
    w_valid  = 1'b0;
    busy     = 1'b1;
    w_accept = 1'b0;
    w_beat   = 1'b0;
    case (r_state)
      IDLE: begin
        busy     = 1'b0;
        w_accept = start;
        if (start) w_next = RUN;
      end
      RUN: begin
        s_ready = 1'b1;
        w_beat  = s_valid;
        if (s_valid && r_beat == LAST_BEAT) w_next = DRAIN;
      end
      DRAIN: if (r_drain == 2'd2) w_next = FINAL;
      FINAL: if (r_idx == LAST_CH) w_next = DONE;
      DONE: begin
        w_valid = 1'b1;
        if (w_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Stage 1 projects the incoming column onto the latched weight vector.
  always_comb begin
    w_dot = '0;
    for (int i = 0; i < N_CH; i++) w_dot = w_dot + extD(r_w[i]) * extD(s_data[i]);
    w_y1Full = w_dot >>> FRAC;
    w_y1     = satV(w_y1Full);
    w_y1Ovf  = ovf(w_y1Full);
  end

  // Stage 2 evaluates the nonlinearity and its derivative. In pow3 mode,
  // y^3 is formed from an already clamped y^2, so both steps can report
  // saturation.
  always_comb begin
    w_yExt    = extD(r_s1Y);
    w_yy      = w_yExt * w_yExt;
    w_yyShift = w_yy >>> FRAC;
    w_sq      = '0;
    if (G_MODE == 1) begin
      w_gFull  = w_yyShift;
      w_gdFull = w_yExt + w_yExt;
      w_s2Ovf  = ovf(w_gFull) || ovf(w_gdFull);
    end else begin
      w_sq     = extD(satV(w_yyShift));
      w_gFull  = (w_sq * w_yExt) >>> FRAC;
      w_gdFull = (w_yy + w_yy + w_yy) >>> FRAC;
      w_s2Ovf  = ovf(w_yyShift) || ovf(w_gFull) || ovf(w_gdFull);
    end
    w_g  = satV(w_gFull);
    w_gd = satV(w_gdFull);
  end

  // Final step for the channel selected by r_idx. The shift by LOG2_M turns
  // the accumulated sums into means. This is the only place the shared
  // multiplier is used.
  always_comb begin
    w_a      = extA(r_accX[r_idx]) >>> (FRAC + LOG2_M);
    w_b      = extA(r_accD) >>> LOG2_M;
    w_fin    = w_a - ((w_b * extD(r_w[r_idx])) >>> FRAC);
    w_finSat = satV(w_fin);
    w_finOvf = ovf(w_fin);
  end

  // Datapath: weight latch, the pipeline registers, the accumulators, the
  // counters and the sticky saturation flag. Pipeline valids are empty
  // whenever a start can be accepted, so clearing the accumulators on start
  // never drops a live beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_CH; i++) begin
        r_w[i]    <= '0;
        r_wOut[i] <= '0;
        r_accX[i] <= '0;
        r_s1X[i]  <= '0;
        r_s2X[i]  <= '0;
      end
      r_accD    <= '0;
      r_beat    <= '0;
      r_drain   <= '0;
      r_idx     <= '0;
      r_sat     <= 1'b0;
      r_s1Valid <= 1'b0;
      r_s2Valid <= 1'b0;
      r_s1Y     <= '0;
      r_s2G     <= '0;
      r_s2Gd    <= '0;
    end else begin
      r_s1Valid <= w_beat;
      if (w_beat) begin
        r_s1Y <= w_y1;
        for (int i = 0; i < N_CH; i++) r_s1X[i] <= s_data[i];
      end
      r_s2Valid <= r_s1Valid;
      if (r_s1Valid) begin
        r_s2G  <= w_g;
        r_s2Gd <= w_gd;
        for (int i = 0; i < N_CH; i++) r_s2X[i] <= r_s1X[i];
      end
      if (w_accept) begin
        for (int i = 0; i < N_CH; i++) begin
          r_w[i]    <= w_in[i];
          r_accX[i] <= '0;
        end
        r_accD <= '0;
        r_beat <= '0;
      end else begin
        if (r_s2Valid) begin
          for (int i = 0; i < N_CH; i++)
            r_accX[i] <= r_accX[i] + extDA(r_s2X[i]) * extDA(r_s2G);
          r_accD <= r_accD + extDA(r_s2Gd);
        end
        if (w_beat) r_beat <= r_beat + BEAT_W'(1);
      end
      if (w_accept)
        r_sat <= 1'b0;
      else if ((w_beat && w_y1Ovf) || (r_s1Valid && w_s2Ovf) || (r_state == FINAL && w_finOvf))
        r_sat <= 1'b1;
      r_drain <= (r_state == DRAIN) ? r_drain + 2'd1 : 2'd0;
      if (r_state == FINAL) begin
        r_wOut[r_idx] <= w_finSat;
        r_idx         <= r_idx + CH_W'(1);
      end else begin
        r_idx <= '0;
      end
    end
  end

  // Present the held result as the packed output vector.
  always_comb begin
    for (int i = 0; i < N_CH; i++) w_out[i] = r_wOut[i];
  end

  assign sat_flag = r_sat;

endmodule
